motor_bridge_n: RTL and testbench
=================================

Name: motor_bridge_n

Overview:
- NCH-channel H-bridge motor driver, successor to the single-channel combinational motor logic.
- Generates its own PWM from a shared period counter instead of taking an external Pwm input.
- Latches duty and control glitch-free at each PWM wrap.
- Inserts programmable dead time between output-state changes.
- Runs a back-EMF measure sequence with a settle delay and a measure-window flag to the ADC sequencer.
- Sits between the bus register file (duty/control/period) and the bridge pins.

Parameters:
- NCH, 4: number of motor channels.
- PWMW, 10: width of the PWM counter, Period and each Duty field.
- DEADW, 4: width of DeadTime.
- SETTLE, 32: cycles of coast before MeasureWin asserts (≥1).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Period  in  PWMW  PWM period minus 1; period is Period+1 cycles.
- DeadTime  in  DEADW  dead-time cycles; 0 disables dead time.
- Duty  in  NCH*PWMW  per-channel duty; channel i uses bits [i*PWMW +: PWMW].
- Control  in  2*NCH  per-channel mode [2i+1:2i]: 00 coast, 01 forward, 10 reverse, 11 brake.
- MeasureReq  in  NCH  per-channel back-EMF measure request, level.
- MotorA  out  NCH  forward high-side drive.
- MotorB  out  NCH  reverse high-side drive.
- MotorC  out  NCH  coast / fast-decay enable.
- MeasureWin  out  NCH  back-EMF valid window.
- PwmSync  out  1  one-cycle pulse when the counter wraps.

Behaviour:
- Reset, asynchronous: counter=0; DutyL=0; CtrlL=00; every channel in COAST (A=0, B=0, C=1); MeasureWin=0; PwmSync=0; dead and settle counters=0.
- Counter: counts 0..Period, then wraps to 0.
- PwmSync: registered; high in the cycle after count==Period.
- Latching: Duty and Control are sampled into DutyL/CtrlL when count==Period. Mid-period changes have no effect until the wrap.
- Period changes take effect immediately. If count>Period, the counter wraps to 0 on the next cycle.
- PWM compare: pwm_i = (count < DutyL_i).
  - DutyL=0 gives 0%.
  - DutyL>Period gives 100%.
  - Period=0 gives a 1-cycle period.
- Per-channel target, evaluated every cycle:
  - MeasureReq_i or CtrlL_i==00 → COAST.
  - else CtrlL_i==11 or !pwm_i → BRAKE.
  - else 01 → FWD, 10 → REV.
- Output encoding per state:
  - COAST: A=0, B=0, C=1.
  - BRAKE: A=0, B=0, C=0.
  - FWD: A=1, B=0, C=0.
  - REV: A=0, B=1, C=0.
  - DEAD: A=0, B=0, C=0.
- FSM states: COAST, BRAKE, FWD, REV, DEAD.
  - If target==state, hold.
  - If target≠state and DeadTime==0, go straight to target.
  - If target≠state and DeadTime>0, go to DEAD with dcnt=DeadTime-1.
  - DEAD: decrement dcnt each cycle; when dcnt==0, go to the target evaluated in that cycle. The target may have changed during DEAD.
  - FWD↔REV must never be adjacent without DEAD when DeadTime>0.
- Outputs are registered: 1-cycle latency from a target change to the first pin change.
- Measure sequence:
  - scnt clears whenever the state is not COAST or MeasureReq_i=0.
  - scnt increments in COAST while MeasureReq_i=1, saturating at SETTLE.
  - MeasureWin_i=1 iff MeasureReq_i=1 and scnt==SETTLE, registered.
  - When MeasureReq_i drops: MeasureWin_i falls in the next cycle, and the channel leaves COAST via the normal dead-time rule.
- Simultaneous events: MeasureReq has priority over control/PWM in the same cycle. A wrap and a target change in the same cycle use the newly latched values on the following cycle.
- Reset mid-DEAD or mid-settle: outputs go to the reset values immediately, with no glitch through the drive states.

Decomposition:
- Package motor_pkg holds:
  - control-code constants CTRL_COAST, CTRL_FWD, CTRL_REV, CTRL_BRAKE;
  - the channel state enum (COAST, BRAKE, FWD, REV, DEAD);
  - an output-encoding function from state to {A,B,C}.
- Sub-module motor_bridge_ch: one channel's latch, compare, FSM, dead counter and settle counter.
- The top holds the shared counter and PwmSync, and generates NCH instances of motor_bridge_ch.

Test Plan:
- Reset, then Period=9, Duty0=3, Control0=01, DeadTime=0: after the first PwmSync, ch0 has A=1 for 3 of every 10 cycles and is in BRAKE (A=B=C=0) for the other 7; PwmSync repeats every 10 cycles.
- Duty0=0 → A never asserts. Duty0=10 with Period=9 → A stays at 1 continuously with no brake cycles.
- DeadTime=3, Duty0=10, Control0 changed 01→10 mid-period: no change until the wrap; then exactly 3 DEAD cycles (A=B=C=0), then B=1; A and B are never high in the same cycle.
- MeasureReq0=1 while in FWD, DeadTime=2, SETTLE=32: DEAD for 2 cycles, then C=1; MeasureWin0 rises 32 cycles after COAST entry. MeasureReq0=0 → MeasureWin0 low the next cycle, then DEAD for 2 cycles, then resume driving.
- Drive 4 channels with distinct duties (1, 5, 9, 10 at Period=9) and control changes written mid-period: per-channel duty cycles are independent, and every channel's updates take effect only at the wrap.
- Assert Reset while ch2 is in DEAD and ch3 is mid-settle: all channels go immediately to A=0, B=0, C=1 and MeasureWin=0, and the counter is 0.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the multi-channel H-bridge motor driver.
//   - CTRL_* : per-channel control codes as written by the register file
//   - chState_t : bridge state of one channel
//   - encodeState : bridge state -> pin levels {A, B, C}
package motor_pkg;

  localparam logic [1:0] CTRL_COAST = 2'b00;
  localparam logic [1:0] CTRL_FWD   = 2'b01;
  localparam logic [1:0] CTRL_REV   = 2'b10;
  localparam logic [1:0] CTRL_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    COAST = 3'd0,
    BRAKE = 3'd1,
    FWD   = 3'd2,
    REV   = 3'd3,
    DEAD  = 3'd4
  } chState_t;

  // Returns {A, B, C}. BRAKE and DEAD both drive all pins low; they differ
  // only in how the state machine leaves them.
  function automatic logic [2:0] encodeState(input chState_t s);
    case (s)
      COAST:   encodeState = 3'b001;
      FWD:     encodeState = 3'b100;
      REV:     encodeState = 3'b010;
      default: encodeState = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/motor_bridge_ch.sv
// One channel of the H-bridge driver.
// Holds the wrap-latched duty/control, the PWM compare against the shared
// counter, the bridge state machine with dead-time insertion, and the
// back-EMF settle counter that produces the measure window.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   cnt          shared PWM counter value
//   latchEn      high in the last cycle of the period; duty/ctrl sampled then
//   duty, ctrl   raw duty and control code from the register file
//   deadTime     dead-time length in cycles (0 = none)
//   measReq      back-EMF measure request (level)
//   motorA/B/C   registered bridge pins
//   measWin      registered back-EMF valid window
module motor_bridge_ch
  import motor_pkg::*;
#(
  parameter int PWMW   = 10,
  parameter int DEADW  = 4,
  parameter int SETTLE = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PWMW-1:0]  cnt,
  input  logic             latchEn,
  input  logic [PWMW-1:0]  duty,
  input  logic [1:0]       ctrl,
  input  logic [DEADW-1:0] deadTime,
  input  logic             measReq,
  output logic             motorA,
  output logic             motorB,
  output logic             motorC,
  output logic             measWin
);

  localparam int SCW = $clog2(SETTLE + 1);

  logic [PWMW-1:0]  dutyL;
  logic [1:0]       ctrlL;
  chState_t         state;
  chState_t         nextState;
  chState_t         target;
  logic [DEADW-1:0] dcnt;
  logic [DEADW-1:0] dcntNext;
  logic [SCW-1:0]   scnt;
  logic [SCW-1:0]   scntNext;
  logic             pwm;

  // Target: a measure request forces coast ahead of anything else; an
  // inactive PWM phase brakes (slow decay) instead of coasting.
  always_comb begin
    pwm = (cnt < dutyL);
    if (measReq || (ctrlL == CTRL_COAST)) begin
      target = COAST;
    end else if ((ctrlL == CTRL_BRAKE) || !pwm) begin
      target = BRAKE;
    end else if (ctrlL == CTRL_FWD) begin
      target = FWD;
    end else begin
      target = REV;
    end
  end

  // Every state change passes through DEAD when dead time is enabled, which
  // keeps FWD and REV from ever being adjacent. DEAD exits to whatever the
  // target is in its final cycle, not the target that started it.
  always_comb begin
    nextState = state;
    dcntNext  = dcnt;
    if (state == DEAD) begin
      if (dcnt == '0) begin
        nextState = target;
      end else begin
        dcntNext = dcnt - DEADW'(1);
      end
    end else if (target != state) begin
      if (deadTime == '0) begin
        nextState = target;
      end else begin
        nextState = DEAD;
        dcntNext  = deadTime - DEADW'(1);
      end
    end
  end

  // Settle counter runs only while actually coasting with a request pending.
  always_comb begin
    if ((state == COAST) && measReq) begin
      scntNext = (scnt == SCW'(SETTLE)) ? scnt : scnt + SCW'(1);
    end else begin
      scntNext = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dutyL   <= '0;
      ctrlL   <= CTRL_COAST;
      state   <= COAST;
      dcnt    <= '0;
      scnt    <= '0;
      motorA  <= 1'b0;
      motorB  <= 1'b0;
      motorC  <= 1'b1;
      measWin <= 1'b0;
    end else begin
      if (latchEn) begin
        dutyL <= duty;
        ctrlL <= ctrl;
      end
      state <= nextState;
      dcnt  <= dcntNext;
      scnt  <= scntNext;
      {motorA, motorB, motorC} <= encodeState(nextState);
      // scntNext is zero unless measReq is high, so this also drops the
      // window the cycle after the request goes away.
      measWin <= (scntNext == SCW'(SETTLE));
    end
  end

endmodule

// File: rtl/motor_bridge_n.sv
// NCH-channel H-bridge motor driver.
// A shared free-running period counter produces the PWM timebase and a
// one-cycle PwmSync pulse at each wrap; each channel latches its duty and
// control at the wrap and drives its bridge pins with dead-time insertion
// and a back-EMF measure sequence.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   Period       PWM period minus one
//   DeadTime     dead-time cycles, 0 disables
//   Duty         per-channel duty, channel i at [i*PWMW +: PWMW]
//   Control      per-channel mode at [2i+1:2i]
//   MeasureReq   per-channel back-EMF measure request
//   MotorA/B/C   forward drive / reverse drive / coast enable
//   MeasureWin   back-EMF valid window
//   PwmSync      one-cycle pulse after the counter wraps
module motor_bridge_n
  import motor_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int PWMW   = 10,
  parameter int DEADW  = 4,
  parameter int SETTLE = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PWMW-1:0]     Period,
  input  logic [DEADW-1:0]    DeadTime,
  input  logic [NCH*PWMW-1:0] Duty,
  input  logic [2*NCH-1:0]    Control,
  input  logic [NCH-1:0]      MeasureReq,
  output logic [NCH-1:0]      MotorA,
  output logic [NCH-1:0]      MotorB,
  output logic [NCH-1:0]      MotorC,
  output logic [NCH-1:0]      MeasureWin,
  output logic                PwmSync
);

  logic [PWMW-1:0] cnt;
  logic            latchEn;

  assign latchEn = (cnt == Period);

  // The >= compare lets a shrunken Period pull an overrun counter straight
  // back to zero instead of running it up to the top of its range.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      PwmSync <= 1'b0;
    end else begin
      PwmSync <= latchEn;
      cnt     <= (cnt >= Period) ? '0 : cnt + PWMW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : gCh
    motor_bridge_ch #(
      .PWMW  (PWMW),
      .DEADW (DEADW),
      .SETTLE(SETTLE)
    ) uCh (
      .Clk     (Clk),
      .Reset   (Reset),
      .cnt     (cnt),
      .latchEn (latchEn),
      .duty    (Duty[i*PWMW +: PWMW]),
      .ctrl    (Control[2*i +: 2]),
      .deadTime(DeadTime),
      .measReq (MeasureReq[i]),
      .motorA  (MotorA[i]),
      .motorB  (MotorB[i]),
      .motorC  (MotorC[i]),
      .measWin (MeasureWin[i])
    );
  end

endmodule

// File: tb/tb_motor_bridge_n.sv
// Scoreboard bench for motor_bridge_n. The stimulus process pushes
// hand-derived expected pin words tagged with the cycle they apply to; the
// monitor samples every cycle just after the falling edge, pops the entries
// due and compares, and also checks that A and B are never high together.
module tb_motor_bridge_n;

  localparam int NCH = 4;
  localparam int PWMW = 10;
  localparam int DEADW = 4;
  localparam int SETTLE = 32;

  localparam int XC = 0;  // coast
  localparam int XB = 1;  // brake
  localparam int XF = 2;  // forward
  localparam int XR = 3;  // reverse
  localparam int XD = 4;  // dead

  localparam logic [16:0] MALL  = 17'h1FFFF;
  localparam logic [16:0] MCH23 = 17'h1CCCC;

  logic                Clk;
  logic                Reset;
  logic [PWMW-1:0]     Period;
  logic [DEADW-1:0]    DeadTime;
  logic [NCH*PWMW-1:0] Duty;
  logic [2*NCH-1:0]    Control;
  logic [NCH-1:0]      MeasureReq;
  logic [NCH-1:0]      MotorA;
  logic [NCH-1:0]      MotorB;
  logic [NCH-1:0]      MotorC;
  logic [NCH-1:0]      MeasureWin;
  logic                PwmSync;

  typedef struct {
    int          cyc;
    logic [16:0] exp;
    logic [16:0] mask;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   base = 0;

  motor_bridge_n #(
    .NCH(NCH), .PWMW(PWMW), .DEADW(DEADW), .SETTLE(SETTLE)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Period    (Period),
    .DeadTime  (DeadTime),
    .Duty      (Duty),
    .Control   (Control),
    .MeasureReq(MeasureReq),
    .MotorA    (MotorA),
    .MotorB    (MotorB),
    .MotorC    (MotorC),
    .MeasureWin(MeasureWin),
    .PwmSync   (PwmSync)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Expected pin word {sync, win[3:0], C[3:0], B[3:0], A[3:0]} from the
  // state letter of each channel.
  function automatic logic [16:0] mkw(input int s0, input int s1, input int s2,
                                      input int s3, input logic [3:0] w,
                                      input logic sy);
    logic [3:0] a, b, c;
    int s[4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == XC) c[i] = 1'b1;
      if (s[i] == XF) a[i] = 1'b1;
      if (s[i] == XR) b[i] = 1'b1;
    end
    return {sy, w, c, b, a};
  endfunction

  task automatic push(input int c, input string nm, input logic [16:0] e,
                      input logic [16:0] m);
    exp_t it;
    it.cyc = c; it.exp = e; it.mask = m; it.name = nm;
    q.push_back(it);
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [16:0] obs;
    forever begin
      @(negedge Clk);
      #1;
      obs = {PwmSync, MeasureWin, MotorC, MotorB, MotorA};
      total++;
      if ((MotorA & MotorB) != '0) begin
        bad++;
        $display("FAIL shoot_through cyc=%0d A=%b B=%b required A&B=0", cyc, MotorA, MotorB);
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %s stale entry for cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
        end else if ((obs & e.mask) != (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", e.name, cyc - base, obs, e.exp, e.mask);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int s0, s1, s2, s3, p, j;
    logic [16:0] rstw;
    rstw = mkw(XC, XC, XC, XC, 4'b0, 1'b0);

    Reset = 1'b1;
    Period = 10'd9;
    DeadTime = '0;
    Duty = '0;
    Control = '0;
    MeasureReq = '0;
    Duty[0 +: PWMW] = 10'd3;
    Control[1:0] = 2'b01;
    for (int c = 1; c <= 3; c++) push(c, "reset", rstw, MALL);

    waitCyc(3);
    Reset = 1'b0;
    base = 3;

    // 30% forward, brake for the rest, sync every 10 cycles
    for (int k = 1; k <= 30; k++) begin
      s0 = (k <= 10) ? XC : ((((k - 11) % 10) < 3) ? XF : XB);
      push(base + k, "duty3", mkw(s0, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);
    end

    // Duty 0 written mid-period: never forward after the wrap
    waitCyc(base + 25);
    Duty[0 +: PWMW] = 10'd0;
    for (int k = 31; k <= 40; k++)
      push(base + k, "duty0", mkw(XB, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);

    // Duty 10 > Period: forward continuously across wraps
    waitCyc(base + 35);
    Duty[0 +: PWMW] = 10'd10;
    for (int k = 41; k <= 55; k++)
      push(base + k, "duty100", mkw(XF, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);

    // FWD -> REV with 3 dead cycles, applied only at the wrap
    waitCyc(base + 55);
    DeadTime = 4'd3;
    Control[1:0] = 2'b10;
    for (int k = 56; k <= 75; k++) begin
      s0 = (k <= 60) ? XF : (k <= 63) ? XD : XR;
      push(base + k, "fwd2rev", mkw(s0, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);
    end

    // Back to forward with 2 dead cycles
    waitCyc(base + 75);
    Control[1:0] = 2'b01;
    DeadTime = 4'd2;
    for (int k = 76; k <= 90; k++) begin
      s0 = (k <= 80) ? XR : (k <= 82) ? XD : XF;
      push(base + k, "rev2fwd", mkw(s0, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);
    end

    // Measure request: dead, coast, window after SETTLE cycles of coast
    waitCyc(base + 90);
    MeasureReq[0] = 1'b1;
    for (int k = 91; k <= 130; k++) begin
      s0 = (k <= 92) ? XD : XC;
      push(base + k, "measure", mkw(s0, XC, XC, XC, {3'b0, k >= 125}, (k % 10) == 0), MALL);
    end

    // Request released: window drops next cycle, dead, then drive again
    waitCyc(base + 130);
    MeasureReq[0] = 1'b0;
    for (int k = 131; k <= 145; k++) begin
      s0 = (k <= 132) ? XD : XF;
      push(base + k, "measend", mkw(s0, XC, XC, XC, 4'b0, (k % 10) == 0), MALL);
    end

    // Four channels with independent duties, changes written mid-period
    waitCyc(base + 145);
    DeadTime = 4'd0;
    Duty = {10'd10, 10'd9, 10'd5, 10'd1};
    Control = {2'b01, 2'b10, 2'b01, 2'b01};
    for (int k = 146; k <= 170; k++) begin
      if (k <= 150) begin
        s0 = XF; s1 = XC; s2 = XC; s3 = XC;
      end else begin
        j = k - 150;
        p = ((j - 1) % 10) + 1;
        s0 = (p == 1) ? XF : XB;
        s2 = (p <= 9) ? XR : XB;
        if (k <= 160) begin
          s1 = (p <= 5) ? XF : XB;
          s3 = XF;
        end else begin
          s1 = XB;
          s3 = XR;
        end
      end
      push(base + k, "multich", mkw(s0, s1, s2, s3, 4'b0, (k % 10) == 0), MALL);
    end
    waitCyc(base + 155);
    Control[3:2] = 2'b11;
    Control[7:6] = 2'b10;

    // Long dead time: ch2 cycles through DEAD, ch3 coasts into settle
    waitCyc(base + 170);
    DeadTime = 4'd15;
    MeasureReq[3] = 1'b1;
    for (int k = 171; k <= 194; k++) begin
      s2 = (k <= 185) ? XD : (k <= 189) ? XR : XD;
      s3 = (k <= 185) ? XD : XC;
      push(base + k, "deadsettle", mkw(XC, XC, s2, s3, 4'b0, (k % 10) == 0), MCH23);
    end

    // Reset with ch2 in DEAD and ch3 mid-settle
    waitCyc(base + 195);
    Reset = 1'b1;
    MeasureReq = '0;
    for (int k = 195; k <= 197; k++) push(base + k, "midreset", rstw, MALL);
    waitCyc(base + 197);
    Reset = 1'b0;

    // Counter restarts from 0: first sync 10 cycles later, then all channels
    // leave coast through DEAD with the freshly latched controls
    for (int k = 198; k <= 207; k++)
      push(base + k, "postreset", mkw(XC, XC, XC, XC, 4'b0, k == 207), MALL);
    push(base + 208, "postlatch", mkw(XD, XD, XD, XD, 4'b0, 1'b0), MALL);

    waitCyc(base + 212);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
